// File: rtl/accel_wb_pkg.sv
// Shared types and constants for the accelerator Wishbone DMA initiator.
// Covers FSM state encoding, completion codes and accelerator window offsets.
package accel_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_GAP,
    WR_REQ,
    WR_GAP,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ABORT   = 2'd2
  } err_t;

  localparam logic [3:0]  WB_SEL_FULL    = 4'hF;
  localparam logic [31:0] WORD_BYTES     = 32'd4;

  localparam logic [31:0] ACC_BASE       = 32'h3000_0000;
  localparam logic [31:0] ACC_OP_OFS     = 32'd0;
  localparam logic [31:0] ACC_STATUS_OFS = 32'd4;
  localparam logic [31:0] ACC_SRAM_OFS   = 32'd8;

  // Byte address of SRAM word idx inside the accelerator window.
  function automatic logic [31:0] acc_sram_addr(input logic [31:0] idx);
    return ACC_BASE + ACC_SRAM_OFS + idx * WORD_BYTES;
  endfunction

endpackage

// File: rtl/accel_wb_beat_timer.sv
// Per-beat wait counter: cleared when a beat starts, counts cycles of STB
// without ACK and flags the cycle on which the TIMEOUT-th wait would occur.
module accel_wb_beat_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Counter already holds TIMEOUT-1 completed waits; this edge is the last one.
  assign expired = en && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/accel_wb_dma_master.sv
// Wishbone classic-cycle DMA initiator: copies cmd_len_i words from cmd_src_i
// to cmd_dst_i as read/write beat pairs, with per-beat timeout and abort.
module accel_wb_dma_master
  import accel_wb_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_src_i,
  input  logic [31:0]      cmd_dst_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             abort_i,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_code_o,
  output logic [LEN_W-1:0] words_done_o
);

  state_t             state, next;
  err_t               err_d;
  logic [31:0]        src, dst, word_buf;
  logic [31:0]        adr_d, dat_d;
  logic [LEN_W-1:0]   remaining;
  logic               in_beat_d;
  logic               accept;
  logic               timer_load, timer_en, timer_expired;

  assign accept     = (state == IDLE) && cmd_valid_i;
  assign timer_en   = wbm_stb_o && !wbm_ack_i;
  assign timer_load = in_beat_d && (next != state);

  accel_wb_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    next  = state;
    err_d = err_t'(err_code_o);
    unique case (state)
      IDLE: if (cmd_valid_i) begin
        err_d = ERR_OK;
        next  = (cmd_len_i != '0) ? RD_REQ : FINISH;
      end
      RD_REQ, WR_REQ: begin
        // A beat acked on the abort edge still completes before finishing.
        if (wbm_ack_i) begin
          if (abort_i) begin
            next  = FINISH;
            err_d = ERR_ABORT;
          end else begin
            next = (state == RD_REQ) ? RD_GAP : WR_GAP;
          end
        end else if (abort_i) begin
          next  = FINISH;
          err_d = ERR_ABORT;
        end else if (timer_expired) begin
          next  = FINISH;
          err_d = ERR_TIMEOUT;
        end
      end
      RD_GAP: begin
        next = WR_REQ;
        if (abort_i) begin
          next  = FINISH;
          err_d = ERR_ABORT;
        end
      end
      WR_GAP: begin
        next = (remaining == '0) ? FINISH : RD_REQ;
        if (abort_i) begin
          next  = FINISH;
          err_d = ERR_ABORT;
        end
      end
      FINISH:  next = IDLE;
      default: next = IDLE;
    endcase

    in_beat_d = (next == RD_REQ) || (next == WR_REQ);
    adr_d     = wbm_adr_o;
    dat_d     = wbm_dat_o;
    if ((next == RD_REQ) && (state != RD_REQ)) begin
      adr_d = (state == IDLE) ? cmd_src_i : src;
    end
    if ((next == WR_REQ) && (state != WR_REQ)) begin
      adr_d = dst;
      dat_d = word_buf;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_sel_o    <= '0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      cmd_ready_o  <= 1'b1;
      err_code_o   <= ERR_OK;
      words_done_o <= '0;
      src          <= '0;
      dst          <= '0;
      word_buf     <= '0;
      remaining    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state       <= next;
      wbm_cyc_o   <= in_beat_d;
      wbm_stb_o   <= in_beat_d;
      wbm_we_o    <= (next == WR_REQ);
      wbm_sel_o   <= in_beat_d ? WB_SEL_FULL : 4'h0;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      busy_o      <= (next != IDLE);
      cmd_ready_o <= (next == IDLE);
      done_o      <= (state == FINISH);
      err_code_o  <= err_d;

      if (accept) begin
        src          <= cmd_src_i;
        dst          <= cmd_dst_i;
        remaining    <= cmd_len_i;
        words_done_o <= '0;
      end
      if ((state == RD_REQ) && wbm_ack_i) begin
        word_buf <= wbm_dat_i;
      end
      if ((state == WR_REQ) && wbm_ack_i) begin
        words_done_o <= words_done_o + LEN_W'(1);
        src          <= src + WORD_BYTES;
        dst          <= dst + WORD_BYTES;
        remaining    <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accel_wb_dma_master.sv
// Bench for accel_wb_dma_master: latency-configurable Wishbone slave memory,
// a word-copy reference model and directed plus randomized copy commands.
module tb_accel_wb_dma_master;
  import accel_wb_pkg::*;

  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_src, cmd_dst;
  logic [LEN_W-1:0] cmd_len;
  logic             abort = 1'b0;
  logic             cyc, stb, we;
  logic [3:0]       sel;
  logic [31:0]      adr, dat_o;
  logic [31:0]      dat_i = '0;
  logic             ack = 1'b0;
  logic             busy, done;
  logic [1:0]       err_code;
  logic [LEN_W-1:0] words_done;

  accel_wb_dma_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_src_i    (cmd_src),
    .cmd_dst_i    (cmd_dst),
    .cmd_len_i    (cmd_len),
    .abort_i      (abort),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_sel_o    (sel),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_ack_i    (ack),
    .busy_o       (busy),
    .done_o       (done),
    .err_code_o   (err_code),
    .words_done_o (words_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  int total = 0;
  int bad   = 0;

  // Environment knobs, written only by the stimulus block.
  int          lat      = 1;
  int          hold_rd  = 0;
  int          hold_wr  = 0;
  int          abort_wr = 0;
  logic [31:0] salt     = '0;

  // Slave-side bookkeeping, written only by the slave process.
  beat_t       log_q[$];
  logic [31:0] mem[logic [31:0]];
  int          rd_seen  = 0;
  int          wr_seen  = 0;
  int          wait_cnt = 0;
  int          last_run = 0;

  int done_total = 0;
  int cyc_total  = 0;

  // Reference memory, written only by the stimulus block.
  logic [31:0] ref_mem[logic [31:0]];

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : seed_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  // Slave decides ACK on the falling edge from the registered bus outputs.
  always @(negedge clk) begin
    beat_t b;
    ack   = 1'b0;
    abort = 1'b0;
    if (!rst_n || !(cyc && stb)) begin
      if (wait_cnt != 0) last_run = wait_cnt;
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) begin
        if (we) wr_seen++;
        else    rd_seen++;
      end
      wait_cnt++;
      if (wait_cnt >= lat && !(!we && rd_seen == hold_rd) && !(we && wr_seen == hold_wr)) begin
        ack = 1'b1;
        if (we) begin
          mem[adr] = dat_o;
          b = '{we: 1'b1, adr: adr, dat: dat_o};
          if (wr_seen == abort_wr) abort = 1'b1;
        end else begin
          dat_i = slave_rd(adr);
          b = '{we: 1'b0, adr: adr, dat: dat_i};
        end
        log_q.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_total++;
    if (cyc)  cyc_total++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc_stb_we"}, {cyc, stb, we}, 3'b000);
    check({tag, "_sel"}, sel, 4'h0);
    check({tag, "_adr"}, adr, 32'h0);
    check({tag, "_dat_o"}, dat_o, 32'h0);
    check({tag, "_busy_done"}, {busy, done}, 2'b00);
    check({tag, "_err"}, err_code, ERR_OK);
    check({tag, "_words_done"}, words_done, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_len   = LEN_W'(n);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns the number of falling edges from the first post-accept sample
  // (counted as 1) to the one that shows done_o high.
  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(negedge clk);
  endtask

  // Expected bus trace: n_rd reads, the first n_wr followed by their writes.
  task automatic verify(input string tag, input logic [31:0] s, input logic [31:0] d,
                        input int n_rd, input int n_wr, input logic [1:0] exp_err,
                        input int log_base, input int done_base);
    int idx;
    logic [31:0] a, data;
    idx = log_base;
    check({tag, "_nbeats"}, log_q.size() - log_base, n_rd + n_wr);
    for (int i = 0; i < n_rd; i++) begin
      a    = s + 32'(i) * 4;
      data = ref_rd(a);
      if (idx < log_q.size()) begin
        check($sformatf("%s_rd%0d_adr", tag, i), {log_q[idx].we, log_q[idx].adr}, {1'b0, a});
        check($sformatf("%s_rd%0d_dat", tag, i), log_q[idx].dat, data);
      end
      idx++;
      if (i < n_wr) begin
        a = d + 32'(i) * 4;
        ref_mem[a] = data;
        if (idx < log_q.size()) begin
          check($sformatf("%s_wr%0d_adr", tag, i), {log_q[idx].we, log_q[idx].adr}, {1'b1, a});
          check($sformatf("%s_wr%0d_dat", tag, i), log_q[idx].dat, data);
        end
        idx++;
      end
    end
    check({tag, "_err"}, err_code, exp_err);
    check({tag, "_words_done"}, words_done, n_wr);
    check({tag, "_done_pulses"}, done_total - done_base, 1);
    check({tag, "_done_low"}, done, 1'b0);
  endtask

  initial begin
    int cyc_n, lb, db, cb, rb;
    logic [31:0] s, d;
    int n;

    salt      = $urandom;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy into the accelerator SRAM window, slave latency 3.
    lat = 3;
    lb = log_q.size(); db = done_total;
    launch(32'h3000_1000, acc_sram_addr(32'd0), 3);
    wait_done("copy3", 400, cyc_n);
    verify("copy3", 32'h3000_1000, 32'h3000_0008, 3, 3, ERR_OK, lb, db);

    // Zero-length command: no bus cycle, done two edges after accept.
    lb = log_q.size(); db = done_total; cb = cyc_total;
    launch(32'h3000_1100, 32'h3000_0020, 0);
    wait_done("len0", 50, cyc_n);
    check("len0_done_latency", cyc_n, 2);
    check("len0_no_cyc", cyc_total - cb, 0);
    verify("len0", 32'h3000_1100, 32'h3000_0020, 0, 0, ERR_OK, lb, db);

    // Second read never acked: beat abandoned after TIMEOUT STB-high cycles.
    lat = 2;
    hold_rd = rd_seen + 2;
    lb = log_q.size(); db = done_total;
    launch(32'h3000_1200, acc_sram_addr(32'd8), 3);
    wait_done("timeout", 400, cyc_n);
    check("timeout_stb_cycles", last_run, TIMEOUT);
    verify("timeout", 32'h3000_1200, acc_sram_addr(32'd8), 1, 1, ERR_TIMEOUT, lb, db);

    // Abort together with the ACK of the second write.
    lat = 1;
    abort_wr = wr_seen + 2;
    lb = log_q.size(); db = done_total; rb = rd_seen;
    launch(32'h3000_1300, acc_sram_addr(32'd16), 4);
    wait_done("abort", 400, cyc_n);
    check("abort_no_third_read", rd_seen - rb, 2);
    verify("abort", 32'h3000_1300, acc_sram_addr(32'd16), 2, 2, ERR_ABORT, lb, db);

    // Destination wraps past the top of the address space.
    lat = int'($urandom_range(1, 4));
    lb = log_q.size(); db = done_total;
    launch(32'h3000_1400, 32'hFFFF_FFFC, 2);
    wait_done("wrap", 400, cyc_n);
    verify("wrap", 32'h3000_1400, 32'hFFFF_FFFC, 2, 2, ERR_OK, lb, db);
    if (log_q.size() > lb + 3) check("wrap_second_wr_adr", log_q[lb + 3].adr, 32'h0);

    // Reset while the first write is stalled on the bus.
    lat = 2;
    hold_wr = wr_seen + 1;
    launch(32'h3000_1500, acc_sram_addr(32'd24), 2);
    n = 0;
    while (!(stb && we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_wr_reached", stb && we, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid_wr");
    rst_n = 1'b1;
    @(negedge clk);
    lb = log_q.size(); db = done_total;
    launch(32'h3000_1600, acc_sram_addr(32'd32), 2);
    wait_done("after_rst", 400, cyc_n);
    verify("after_rst", 32'h3000_1600, acc_sram_addr(32'd32), 2, 2, ERR_OK, lb, db);

    // Randomized copies with random slave latency.
    for (int k = 0; k < 6; k++) begin
      lat = int'($urandom_range(1, 4));
      s   = 32'h3000_1000 + 32'($urandom_range(0, 255)) * 4;
      d   = acc_sram_addr(32'($urandom_range(0, 63)));
      n   = int'($urandom_range(1, 6));
      lb = log_q.size(); db = done_total;
      launch(s, d, n);
      wait_done($sformatf("rand%0d", k), 400, cyc_n);
      verify($sformatf("rand%0d", k), s, d, n, n, ERR_OK, lb, db);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
